speck_serial_adder: RTL

//  Bit-serial modulo-2^WORD_W adder for the SPECK round datapath (x = (x>>>a) + y).

---
 rtl/speck_serial_adder.sv | 92 +++++++++
 1 files changed

// File: rtl/speck_serial_adder.sv
// Bit-serial modulo-2^WORD_W adder for the SPECK round datapath.
// One bit pair per cycle, LSB first, through a single MIG full-adder cell.
// The carry is held in a flop between cycles, and sum bits shift in from the MSB end.

// Majority-inverter-graph full adder: cout = M(a,b,cin), s = M(~cout, M(a,b,~cin), cin)
module mig_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic m_abn;

  assign cout  = (a & b) | (a & cin) | (b & cin);
  assign m_abn = (a & b) | (a & ~cin) | (b & ~cin);
  assign s     = (~cout & m_abn) | (~cout & cin) | (m_abn & cin);
endmodule

module speck_serial_adder #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] a_sr, b_sr;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic              s_bit, c_bit;

  mig_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Control FSM plus the serial datapath; start is ignored unless IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {s_bit, sum[WORD_W-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            carry_out <= c_bit;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
